// File: rtl/serial_detect_pkg.sv
// Shared constants and sizing helpers for the serial pattern detector.
package serial_detect_pkg;

    localparam int unsigned PAT_W_DEF  = 5;
    localparam int unsigned HIST_W_DEF = 6;
    localparam int unsigned CNT_W_DEF  = 8;

    // Fill counter only has to reach PAT_W-1.
    function automatic int unsigned fill_w(input int unsigned pat_w);
        return $clog2(pat_w);
    endfunction

endpackage

// File: rtl/serial_pattern_detector_sat_counter.sv
// Saturating up-counter with synchronous clear and a registered saturation flag.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         sat_o
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] count_q, count_d;
    logic         sat_q, sat_d;

    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (inc_i && (count_q != MAX)) begin
            count_d = count_q + W'(1);
            sat_d   = (count_d == MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count_o = count_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shifts in qualified bits and pulses z when the newest
// PAT_W bits match a loadable, maskable pattern; counts matches with saturation.
module serial_pattern_detector
    import serial_detect_pkg::*;
#(
    parameter int unsigned      PAT_W       = PAT_W_DEF,
    parameter int unsigned      HIST_W      = HIST_W_DEF,
    parameter int unsigned      CNT_W       = CNT_W_DEF,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(5'b10101)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x,
    input  logic              x_valid,
    input  logic              load,
    input  logic [PAT_W-1:0]  pattern,
    input  logic [PAT_W-1:0]  pat_mask,
    input  logic              overlap,
    output logic              z,
    output logic [HIST_W-1:0] outData,
    output logic [CNT_W-1:0]  match_cnt,
    output logic              cnt_sat
);

    localparam int unsigned          FILL_W    = fill_w(PAT_W);
    localparam logic [FILL_W-1:0]    FILL_FULL = FILL_W'(PAT_W - 1);

    if ((HIST_W < PAT_W) || (PAT_W < 2) || (PAT_W > 16)) begin : g_bad_params
        $error("serial_pattern_detector: need 2 <= PAT_W <= 16 and HIST_W >= PAT_W");
    end

    logic [HIST_W-1:0] hist_q, hist_d;
    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [PAT_W-1:0]  mask_q, mask_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              z_q, z_d;
    logic [PAT_W-1:0]  window;
    logic              hit;

    // Next-state: load beats accept; a bit arriving with load is dropped.
    always_comb begin
        hist_d = hist_q;
        pat_d  = pat_q;
        mask_d = mask_q;
        fill_d = fill_q;
        z_d    = 1'b0;
        hit    = 1'b0;
        window = {hist_q[PAT_W-2:0], x};
        if (load) begin
            pat_d  = pattern;
            mask_d = pat_mask;
            fill_d = '0;
        end else if (x_valid) begin
            hist_d = {hist_q[HIST_W-2:0], x};
            hit    = (fill_q == FILL_FULL) && (((window ^ pat_q) & mask_q) == '0);
            z_d    = hit;
            if (hit && !overlap) begin
                fill_d = '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
            pat_q  <= PAT_DEFAULT;
            mask_q <= '1;
            fill_q <= '0;
            z_q    <= 1'b0;
        end else begin
            hist_q <= hist_d;
            pat_q  <= pat_d;
            mask_q <= mask_d;
            fill_q <= fill_d;
            z_q    <= z_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk     (clk),
        .clr_i   (rst),
        .inc_i   (hit),
        .count_o (match_cnt),
        .sat_o   (cnt_sat)
    );

    assign z       = z_q;
    assign outData = hist_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed bench for serial_pattern_detector: default instance plus a CNT_W=2 instance.
module tb_serial_pattern_detector;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       load = 1'b0;
    logic [4:0] pattern = 5'b0;
    logic [4:0] pat_mask = 5'b0;
    logic       overlap = 1'b1;

    logic       z, z2;
    logic [5:0] out_data, out_data2;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;
    logic       cnt_sat, cnt_sat2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_pattern_detector dut (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .load(load),
        .pattern(pattern), .pat_mask(pat_mask), .overlap(overlap),
        .z(z), .outData(out_data), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
    );

    serial_pattern_detector #(.CNT_W(2)) dut_c2 (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .load(load),
        .pattern(pattern), .pat_mask(pat_mask), .overlap(overlap),
        .z(z2), .outData(out_data2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic ld, input logic v, input logic b);
        rst = r; load = ld; x_valid = v; x = b;
        @(posedge clk);
        #1;
        rst = 1'b0; load = 1'b0; x_valid = 1'b0; x = 1'b0;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [6:0]  s7;
        logic [12:0] s13;

        // Reset state
        #2;
        do_reset();
        check("rst_z", 32'(z), 32'd0);
        check("rst_out", 32'(out_data), 32'd0);
        check("rst_cnt", 32'(match_cnt), 32'd0);
        check("rst_sat", 32'(cnt_sat), 32'd0);

        // Overlapping stream 1010101: hits after bits 5 and 7
        overlap = 1'b1;
        s7 = 7'b1010101;
        for (int i = 6; i >= 0; i--) begin
            step(1'b0, 1'b0, 1'b1, s7[i]);
            check($sformatf("ov_z_b%0d", 7 - i), 32'(z), 32'((i == 2) || (i == 0)));
        end
        check("ov_cnt", 32'(match_cnt), 32'd2);
        check("ov_out", 32'(out_data), 32'(6'b010101));
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("ov_idle_z", 32'(z), 32'd0);

        // Non-overlapping: window restarts, bit 7 is not a hit
        do_reset();
        overlap = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            step(1'b0, 1'b0, 1'b1, s7[i]);
            check($sformatf("nov_z_b%0d", 7 - i), 32'(z), 32'(i == 2));
        end
        check("nov_cnt", 32'(match_cnt), 32'd1);

        // Masked pattern 1xxx1; load coincident with a valid bit drops the bit
        do_reset();
        overlap  = 1'b1;
        pattern  = 5'b10001;
        pat_mask = 5'b10001;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("ldv_out", 32'(out_data), 32'd0);
        check("ldv_z", 32'(z), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            check($sformatf("msk_z_b%0d", i), 32'(z), 32'(i >= 5));
        end
        check("msk_cnt", 32'(match_cnt), 32'd2);
        check("msk_out", 32'(out_data), 32'(6'b111111));

        // Mid-stream reset restores the default pattern and empties the window
        do_reset();
        overlap = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("mr_pre_z", 32'(z), 32'd0);
        check("mr_pre_out", 32'(out_data), 32'(6'b001010));
        do_reset();
        check("mr_rst_out", 32'(out_data), 32'd0);
        check("mr_rst_z", 32'(z), 32'd0);
        s7 = 7'b0010101;
        for (int i = 4; i >= 0; i--) begin
            step(1'b0, 1'b0, 1'b1, s7[i]);
            if (i == 4) check("mr_first_out", 32'(out_data), 32'(6'b000001));
            check($sformatf("mr_z_b%0d", 5 - i), 32'(z), 32'(i == 0));
        end
        check("mr_cnt", 32'(match_cnt), 32'd1);

        // Gapped stream: two idle cycles after each valid bit
        do_reset();
        for (int i = 4; i >= 0; i--) begin
            step(1'b0, 1'b0, 1'b1, s7[i]);
            check($sformatf("gap_z_b%0d", 5 - i), 32'(z), 32'(i == 0));
            for (int k = 0; k < 2; k++) begin
                step(1'b0, 1'b0, 1'b0, 1'b1);
                check($sformatf("gap_idle_z_b%0d_%0d", 5 - i, k), 32'(z), 32'd0);
            end
        end
        check("gap_cnt", 32'(match_cnt), 32'd1);
        check("gap_out", 32'(out_data), 32'(6'b010101));

        // Saturation: five overlapping hits into a 2-bit counter
        do_reset();
        overlap = 1'b1;
        s13 = 13'b1010101010101;
        begin
            int hits = 0;
            for (int i = 12; i >= 0; i--) begin
                step(1'b0, 1'b0, 1'b1, s13[i]);
                if ((i % 2 == 0) && (i <= 8)) begin
                    hits++;
                    check($sformatf("sat_z2_h%0d", hits), 32'(z2), 32'd1);
                    check($sformatf("sat_cnt2_h%0d", hits), 32'(match_cnt2),
                          32'((hits > 3) ? 3 : hits));
                    check($sformatf("sat_flag_h%0d", hits), 32'(cnt_sat2), 32'(hits >= 3));
                end
            end
        end
        check("sat_cnt8", 32'(match_cnt), 32'd5);
        check("sat_flag8", 32'(cnt_sat), 32'd0);

        // Empty mask with a full window hits on every accepted bit
        pattern  = 5'b00000;
        pat_mask = 5'b00000;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 1'b0, 1'b1, i[0]);
            check($sformatf("nomask_z_b%0d", i), 32'(z), 32'(i >= 5));
        end
        check("nomask_cnt", 32'(match_cnt), 32'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
